alu_operand_stage: RTL and testbench

- Registered successor to the combinational ALU operand selector.
- Decodes opcode class and selects ALU operands DATA0/DATA1 from register data, immediates, PC or constant 4.
- Adds EX/WB result forwarding, a store-data path, JAL/JALR/branch support, and a valid/ready pipeline register with an optional skid entry and flush.
- Sits between the register-file read (ID) and the ALU (EX).

---
 rtl/alu_operand_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: forwards rs1/rs2, selects DATA0/DATA1 by opcode and
// holds the result in a valid/ready output register with an optional skid entry.
module alu_operand_stage #(
   parameter int N    = 32,
   parameter int SKID = 1
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [6:0]   OPCODE,
   input  logic [2:0]   FUNCT3,
   input  logic         FUNCT1,
   input  logic [4:0]   RS1,
   input  logic [4:0]   RS2,
   input  logic [4:0]   RD,
   input  logic [N-1:0] RS1_DATA,
   input  logic [N-1:0] RS2_DATA,
   input  logic [N-1:0] PC,
   input  logic [19:0]  U_IMM20,
   input  logic [11:0]  IMM12,
   input  logic         FWD_EX_VALID,
   input  logic [4:0]   FWD_EX_RD,
   input  logic [N-1:0] FWD_EX_DATA,
   input  logic         FWD_WB_VALID,
   input  logic [4:0]   FWD_WB_RD,
   input  logic [N-1:0] FWD_WB_DATA,
   input  logic         FLUSH,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [N-1:0] DATA0,
   output logic [N-1:0] DATA1,
   output logic [N-1:0] STORE_DATA,
   output logic         ALU_EN,
   output logic [4:0]   OUT_RD,
   output logic [2:0]   OUT_FUNCT3,
   output logic         OUT_FUNCT1
);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [N-1:0] data0;
      logic [N-1:0] data1;
      logic [N-1:0] store_data;
      logic         alu_en;
      logic [4:0]   rd;
      logic [2:0]   funct3;
      logic         funct1;
   } entry_t;

   logic [4:0]   src_idx [2];
   logic [N-1:0] src_rf  [2];
   logic [N-1:0] src_fwd [2];

   logic [N-1:0] imm_x;
   logic [N-1:0] u_x;
   logic [N-1:0] shamt;
   logic [N-1:0] op_data0;
   logic [N-1:0] op_data1;
   logic         op_alu_en;

   entry_t new_entry;
   entry_t out_reg;
   logic   out_valid_reg;
   logic   in_ready;

   assign src_idx[0] = RS1;
   assign src_idx[1] = RS2;
   assign src_rf[0]  = RS1_DATA;
   assign src_rf[1]  = RS2_DATA;

   // EX wins over WB because it holds the younger write to the same register.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         assign src_fwd[gi] = (src_idx[gi] == 5'd0)                          ? '0 :
                              (FWD_EX_VALID && (FWD_EX_RD == src_idx[gi]))   ? FWD_EX_DATA :
                              (FWD_WB_VALID && (FWD_WB_RD == src_idx[gi]))   ? FWD_WB_DATA :
                                                                               src_rf[gi];
      end
   endgenerate

   assign imm_x = N'($signed(IMM12));
   assign u_x   = N'($signed({U_IMM20, 12'b0}));
   assign shamt = N'(IMM12[4:0]);

   always_comb begin
      op_data0  = '0;
      op_data1  = '0;
      op_alu_en = 1'b0;
      case (OPCODE)
         OPC_OP_IMM: begin
            op_data0  = src_fwd[0];
            op_data1  = ((FUNCT3 == 3'b001) || (FUNCT3 == 3'b101)) ? shamt : imm_x;
            op_alu_en = 1'b1;
         end
         OPC_OP, OPC_BRANCH: begin
            op_data0  = src_fwd[0];
            op_data1  = src_fwd[1];
            op_alu_en = 1'b1;
         end
         OPC_LOAD, OPC_STORE: begin
            op_data0  = src_fwd[0];
            op_data1  = imm_x;
            op_alu_en = 1'b1;
         end
         OPC_LUI: begin
            op_data1  = u_x;
            op_alu_en = 1'b1;
         end
         OPC_AUIPC: begin
            op_data0  = PC;
            op_data1  = u_x;
            op_alu_en = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            op_data0  = PC;
            op_data1  = N'(32'd4);
            op_alu_en = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign new_entry.data0      = op_data0;
   assign new_entry.data1      = op_data1;
   assign new_entry.store_data = src_fwd[1];
   assign new_entry.alu_en     = op_alu_en;
   assign new_entry.rd         = RD;
   assign new_entry.funct3     = FUNCT3;
   assign new_entry.funct1     = FUNCT1;

   generate
      if (SKID != 0) begin : g_skid
         entry_t skid_reg;
         logic   skid_valid_reg;
         logic   in_ready_reg;
         logic   accept;

         assign in_ready = in_ready_reg;
         assign accept   = IN_VALID & in_ready_reg;

         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               out_valid_reg  <= 1'b0;
               skid_valid_reg <= 1'b0;
               in_ready_reg   <= 1'b0;
               out_reg        <= '0;
               skid_reg       <= '0;
            end else if (FLUSH) begin
               out_valid_reg  <= 1'b0;
               skid_valid_reg <= 1'b0;
               in_ready_reg   <= 1'b1;
            end else if (!out_valid_reg || OUT_READY) begin
               // Output slot frees this edge; a held skid entry always goes first.
               in_ready_reg <= 1'b1;
               if (skid_valid_reg) begin
                  out_reg        <= skid_reg;
                  out_valid_reg  <= 1'b1;
                  skid_valid_reg <= 1'b0;
               end else if (accept) begin
                  out_reg       <= new_entry;
                  out_valid_reg <= 1'b1;
               end else begin
                  out_valid_reg <= 1'b0;
               end
            end else if (accept) begin
               skid_reg       <= new_entry;
               skid_valid_reg <= 1'b1;
               in_ready_reg   <= 1'b0;
            end else begin
               in_ready_reg <= ~skid_valid_reg;
            end
         end
      end else begin : g_noskid
         logic rst_done_reg;

         // Held low through reset so nothing is accepted before the stage is live.
         assign in_ready = rst_done_reg & (~out_valid_reg | OUT_READY);

         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               rst_done_reg  <= 1'b0;
               out_valid_reg <= 1'b0;
               out_reg       <= '0;
            end else begin
               rst_done_reg <= 1'b1;
               if (FLUSH) begin
                  out_valid_reg <= 1'b0;
               end else if (in_ready) begin
                  out_valid_reg <= IN_VALID;
                  if (IN_VALID) begin
                     out_reg <= new_entry;
                  end
               end
            end
         end
      end
   endgenerate

   assign IN_READY   = in_ready;
   assign OUT_VALID  = out_valid_reg;
   assign DATA0      = out_reg.data0;
   assign DATA1      = out_reg.data1;
   assign STORE_DATA = out_reg.store_data;
   assign ALU_EN     = out_reg.alu_en;
   assign OUT_RD     = out_reg.rd;
   assign OUT_FUNCT3 = out_reg.funct3;
   assign OUT_FUNCT1 = out_reg.funct1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage (SKID=1): directed vector table, hand-written
// skid/flush/reset sequences and a randomized run against a queue-based model.
module tb_alu_operand_stage;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  f3;
      logic        f1;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] pc;
      logic [19:0] u;
      logic [11:0] imm;
      logic        exv;
      logic [4:0]  exrd;
      logic [31:0] exd;
      logic        wbv;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
   } vin_t;

   typedef struct packed {
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] sd;
      logic        alu;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        f1;
   } exp_t;

   typedef struct {
      vin_t        in;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] sd;
      logic        alu;
   } vec_t;

   localparam logic [6:0] OPS [11] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h37, 7'h17,
                                       7'h6F, 7'h67, 7'h63, 7'h0F, 7'h73};

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3, out_funct3;
   logic        funct1, out_funct1, alu_en;
   logic [4:0]  rs1, rs2, rd, ex_rd, wb_rd, out_rd;
   logic [31:0] rs1_data, rs2_data, pc, ex_data, wb_data;
   logic [31:0] data0, data1, store_data;
   logic [19:0] u_imm20;
   logic [11:0] imm12;
   logic        ex_valid, wb_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_operand_stage #(.N(32), .SKID(1)) dut (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
      .OPCODE(opcode), .FUNCT3(funct3), .FUNCT1(funct1),
      .RS1(rs1), .RS2(rs2), .RD(rd), .RS1_DATA(rs1_data), .RS2_DATA(rs2_data),
      .PC(pc), .U_IMM20(u_imm20), .IMM12(imm12),
      .FWD_EX_VALID(ex_valid), .FWD_EX_RD(ex_rd), .FWD_EX_DATA(ex_data),
      .FWD_WB_VALID(wb_valid), .FWD_WB_RD(wb_rd), .FWD_WB_DATA(wb_data),
      .FLUSH(flush), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .DATA0(data0), .DATA1(data1), .STORE_DATA(store_data), .ALU_EN(alu_en),
      .OUT_RD(out_rd), .OUT_FUNCT3(out_funct3), .OUT_FUNCT1(out_funct1)
   );

   function automatic vin_t mkv(logic [6:0] op, logic [2:0] f3, logic f1,
                                logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
                                logic [31:0] r1d, logic [31:0] r2d, logic [31:0] p,
                                logic [19:0] u, logic [11:0] imm,
                                logic exv, logic [4:0] exrd, logic [31:0] exd,
                                logic wbv, logic [4:0] wbrd, logic [31:0] wbd);
      vin_t v;
      v.opcode = op; v.f3 = f3; v.f1 = f1; v.rs1 = r1; v.rs2 = r2; v.rd = d;
      v.rs1d = r1d; v.rs2d = r2d; v.pc = p; v.u = u; v.imm = imm;
      v.exv = exv; v.exrd = exrd; v.exd = exd; v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
      return v;
   endfunction

   function automatic vin_t mk_lui(logic [19:0] tag);
      return mkv(7'h37, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, tag, 12'd0,
                 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endfunction

   function automatic logic [31:0] src_value(logic [4:0] idx, logic [31:0] rf, vin_t v);
      if (idx == 0) return 32'd0;
      if (v.exv && v.exrd == idx) return v.exd;
      if (v.wbv && v.wbrd == idx) return v.wbd;
      return rf;
   endfunction

   // Reference: what the instruction should present to the ALU, from the operand rules.
   function automatic exp_t ref_entry(vin_t v);
      exp_t e;
      logic [31:0] s1, s2, immx, ux;
      s1 = src_value(v.rs1, v.rs1d, v);
      s2 = src_value(v.rs2, v.rs2d, v);
      immx = {{20{v.imm[11]}}, v.imm};
      ux = {v.u, 12'd0};
      e = '0;
      e.sd = s2; e.rd = v.rd; e.f3 = v.f3; e.f1 = v.f1; e.alu = 1'b1;
      case (v.opcode)
         7'h13: begin e.d0 = s1; e.d1 = (v.f3 == 3'd1 || v.f3 == 3'd5) ? 32'(v.imm[4:0]) : immx; end
         7'h33, 7'h63: begin e.d0 = s1; e.d1 = s2; end
         7'h03, 7'h23: begin e.d0 = s1; e.d1 = immx; end
         7'h37: e.d1 = ux;
         7'h17: begin e.d0 = v.pc; e.d1 = ux; end
         7'h6F, 7'h67: begin e.d0 = v.pc; e.d1 = 32'd4; end
         default: e.alu = 1'b0;
      endcase
      return e;
   endfunction

   function automatic vin_t rand_vin();
      vin_t v;
      int k;
      k = $urandom_range(0, 11);
      v.opcode = (k == 11) ? 7'($urandom) : OPS[k];
      v.f3 = 3'($urandom); v.f1 = 1'($urandom);
      v.rs1 = 5'($urandom_range(0, 7)); v.rs2 = 5'($urandom_range(0, 7));
      v.rd = 5'($urandom);
      v.rs1d = $urandom; v.rs2d = $urandom; v.pc = $urandom;
      v.u = 20'($urandom); v.imm = 12'($urandom);
      v.exv = 1'($urandom); v.exrd = 5'($urandom_range(0, 7)); v.exd = $urandom;
      v.wbv = 1'($urandom); v.wbrd = 5'($urandom_range(0, 7)); v.wbd = $urandom;
      return v;
   endfunction

   task automatic drive(input vin_t v);
      opcode = v.opcode; funct3 = v.f3; funct1 = v.f1;
      rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; rs1_data = v.rs1d; rs2_data = v.rs2d;
      pc = v.pc; u_imm20 = v.u; imm12 = v.imm;
      ex_valid = v.exv; ex_rd = v.exrd; ex_data = v.exd;
      wb_valid = v.wbv; wb_rd = v.wbrd; wb_data = v.wbd;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic chk_payload(input string tag, input exp_t e);
      chk({tag, ".data0"}, data0, e.d0);
      chk({tag, ".data1"}, data1, e.d1);
      chk({tag, ".store_data"}, store_data, e.sd);
      chk({tag, ".alu_en"}, 32'(alu_en), 32'(e.alu));
      chk({tag, ".out_rd"}, 32'(out_rd), 32'(e.rd));
      chk({tag, ".funct3"}, 32'(out_funct3), 32'(e.f3));
      chk({tag, ".funct1"}, 32'(out_funct1), 32'(e.f1));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [17];
   exp_t q [$];
   exp_t e;
   vin_t v;
   logic exp_ready, rst_last;

   initial begin
      tbl[0]  = '{mkv(7'h13, 3'd0, 1'b0, 5'd3, 5'd0, 5'd1, 32'd10, 32'd0, 32'd0, 20'd0, 12'hFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'd10, 32'hFFFF_FFFF, 32'd0, 1'b1};
      tbl[1]  = '{mkv(7'h33, 3'd0, 1'b0, 5'd5, 5'd5, 5'd2, 32'd1, 32'd1, 32'd0, 20'd0, 12'd0, 1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9), 32'd7, 32'd7, 32'd7, 1'b1};
      tbl[2]  = '{mkv(7'h33, 3'd0, 1'b0, 5'd5, 5'd5, 5'd2, 32'd1, 32'd1, 32'd0, 20'd0, 12'd0, 1'b0, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9), 32'd9, 32'd9, 32'd9, 1'b1};
      tbl[3]  = '{mkv(7'h33, 3'd0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd1, 32'd1, 32'd0, 20'd0, 12'd0, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd9), 32'd0, 32'd0, 32'd0, 1'b1};
      tbl[4]  = '{mkv(7'h17, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h100, 20'h12345, 12'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'h100, 32'h1234_5000, 32'd0, 1'b1};
      tbl[5]  = '{mkv(7'h6F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h200, 20'h0ABCD, 12'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'h200, 32'd4, 32'd0, 1'b1};
      tbl[6]  = '{mkv(7'h13, 3'd1, 1'b0, 5'd1, 5'd0, 5'd4, 32'h55, 32'd0, 32'd0, 20'd0, 12'h405, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'h55, 32'd5, 32'd0, 1'b1};
      tbl[7]  = '{mkv(7'h0F, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h77, 32'h1234, 32'h400, 20'hFFFFF, 12'hFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'd0, 32'd0, 32'h1234, 1'b0};
      tbl[8]  = '{mkv(7'h37, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5, 32'h77, 32'd0, 32'h500, 20'hFFFFF, 12'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'd0, 32'hFFFF_F000, 32'd0, 1'b1};
      tbl[9]  = '{mkv(7'h23, 3'd2, 1'b0, 5'd2, 5'd4, 5'd0, 32'h1000, 32'hABCD, 32'd0, 20'd0, 12'h800, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'h1000, 32'hFFFF_F800, 32'hABCD, 1'b1};
      tbl[10] = '{mkv(7'h63, 3'd1, 1'b0, 5'd6, 5'd7, 5'd0, 32'd1, 32'd2, 32'd0, 20'd0, 12'd0, 1'b1, 5'd7, 32'h99, 1'b1, 5'd6, 32'h42), 32'h42, 32'h99, 32'h99, 1'b1};
      tbl[11] = '{mkv(7'h13, 3'd5, 1'b1, 5'd9, 5'd0, 5'd6, 32'h8000_0000, 32'd0, 32'd0, 20'd0, 12'h41F, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'h8000_0000, 32'h1F, 32'd0, 1'b1};
      tbl[12] = '{mkv(7'h67, 3'd0, 1'b0, 5'd1, 5'd0, 5'd1, 32'h1234, 32'd0, 32'h300, 20'd0, 12'h010, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'h300, 32'd4, 32'd0, 1'b1};
      tbl[13] = '{mkv(7'h03, 3'd2, 1'b0, 5'd8, 5'd0, 5'd7, 32'h2000, 32'd0, 32'd0, 20'd0, 12'h004, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'h2000, 32'd4, 32'd0, 1'b1};
      tbl[14] = '{mkv(7'h13, 3'd6, 1'b0, 5'd1, 5'd0, 5'd2, 32'd5, 32'd0, 32'd0, 20'd0, 12'h405, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'hAA), 32'hAA, 32'h405, 32'd0, 1'b1};
      tbl[15] = '{mkv(7'h33, 3'd0, 1'b1, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'd0, 20'd0, 12'd0, 1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66), 32'h11, 32'h22, 32'h22, 1'b1};
      tbl[16] = '{mkv(7'h7F, 3'd3, 1'b1, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h30, 20'h1, 12'h1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0), 32'd0, 32'd0, 32'h20, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      drive('0);
      repeat (2) tick();
      chk("reset.in_ready", 32'(in_ready), 32'd0);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk_payload("reset", '0);
      rst_n = 1'b1;
      tick();
      chk("release.in_ready", 32'(in_ready), 32'd1);

      // Directed vector table, one instruction at a time with OUT_READY high.
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].in);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         e = '{tbl[i].d0, tbl[i].d1, tbl[i].sd, tbl[i].alu, tbl[i].in.rd, tbl[i].in.f3, tbl[i].in.f1};
         chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
         chk_payload($sformatf("vec%0d", i), e);
         $display("vec %0d opcode=%h data0=%h data1=%h store=%h alu_en=%0d",
                  i, tbl[i].in.opcode, data0, data1, store_data, alu_en);
         tick();
         chk($sformatf("vec%0d.drain", i), 32'(out_valid), 32'd0);
      end

      // Skid: three back-to-back with the output stalled, then release.
      out_ready = 1'b0;
      drive(mk_lui(20'd1)); in_valid = 1'b1; tick();
      chk("skid.a_valid", 32'(out_valid), 32'd1);
      chk("skid.a_ready", 32'(in_ready), 32'd1);
      drive(mk_lui(20'd2)); tick();
      chk("skid.b_ready", 32'(in_ready), 32'd0);
      chk("skid.b_hold", data1, 32'h1000);
      drive(mk_lui(20'd3)); tick();
      chk("skid.c_ready", 32'(in_ready), 32'd0);
      chk("skid.c_hold", data1, 32'h1000);
      out_ready = 1'b1; tick();
      chk("skid.out_b", data1, 32'h2000);
      chk("skid.out_b_valid", 32'(out_valid), 32'd1);
      chk("skid.ready_back", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("skid.out_c", data1, 32'h3000);
      chk("skid.out_c_valid", 32'(out_valid), 32'd1);
      tick();
      chk("skid.empty", 32'(out_valid), 32'd0);
      $display("skid sequence done");

      // Flush with both entries full and an instruction presented.
      out_ready = 1'b0;
      drive(mk_lui(20'd4)); in_valid = 1'b1; tick();
      drive(mk_lui(20'd5)); tick();
      drive(mk_lui(20'd6)); flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush1.out_valid", 32'(out_valid), 32'd0);
      chk("flush1.in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("flush1.quiet%0d", i), 32'(out_valid), 32'd0);
      end
      // Flush coinciding with a real accept.
      out_ready = 1'b0;
      drive(mk_lui(20'd7)); in_valid = 1'b1; tick();
      chk("flush2.pre_ready", 32'(in_ready), 32'd1);
      drive(mk_lui(20'd8)); flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush2.out_valid", 32'(out_valid), 32'd0);
      chk("flush2.in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (2) begin
         tick();
         chk("flush2.quiet", 32'(out_valid), 32'd0);
      end
      drive(mk_lui(20'd9)); in_valid = 1'b1; tick();
      in_valid = 1'b0;
      chk("flush2.next_valid", 32'(out_valid), 32'd1);
      chk("flush2.next_data", data1, 32'h9000);
      tick();
      chk("flush2.next_drain", 32'(out_valid), 32'd0);
      $display("flush sequences done");

      // Reset mid-stall drops everything.
      out_ready = 1'b0;
      drive(mk_lui(20'd10)); in_valid = 1'b1; tick();
      drive(mk_lui(20'd11)); tick();
      drive(mk_lui(20'd12)); rst_n = 1'b0; tick();
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk_payload("rst", '0);
      tick();
      chk("rst.in_ready2", 32'(in_ready), 32'd0);
      rst_n = 1'b1; in_valid = 1'b0; tick();
      chk("rst.release_ready", 32'(in_ready), 32'd1);
      chk("rst.release_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1; tick();
      chk("rst.no_ghost", 32'(out_valid), 32'd0);
      $display("reset sequence done");

      // Randomized traffic against the queue model.
      q.delete();
      rst_last = 1'b0;
      for (int c = 0; c < 800; c++) begin
         exp_ready = !rst_last && (q.size() < 2);
         chk($sformatf("rnd%0d.in_ready", c), 32'(in_ready), 32'(exp_ready));
         chk($sformatf("rnd%0d.out_valid", c), 32'(out_valid), 32'(q.size() > 0));
         if (q.size() > 0) chk_payload($sformatf("rnd%0d", c), q[0]);
         else if (rst_last) chk_payload($sformatf("rnd%0d.rst", c), '0);
         v = rand_vin();
         drive(v);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 31) == 0);
         rst_n     = !($urandom_range(0, 199) == 0);
         @(posedge clk);
         if (!rst_n) begin
            q.delete();
            rst_last = 1'b1;
         end else begin
            rst_last = 1'b0;
            if (flush) begin
               q.delete();
            end else begin
               if (q.size() > 0 && out_ready) begin
                  $display("rnd %0d transfer data0=%h data1=%h rd=%0d", c, q[0].d0, q[0].d1, q[0].rd);
                  void'(q.pop_front());
               end
               if (in_valid && exp_ready) q.push_back(ref_entry(v));
            end
         end
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
